// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, one write port, ALU flag and shift-carry paths.
// The master is the datapath controller/ALU side; the slave is the register file itself.
interface reg_file_if #(
   parameter int W = 8,
   parameter int A = 3
);
   logic [A-1:0] RaddrA;
   logic [A-1:0] RaddrB;
   logic [W-1:0] DataOutA;
   logic [W-1:0] DataOutB;
   logic         WriteEn;
   logic [A-1:0] Waddr;
   logic [W-1:0] DataIn;
   logic         FlagWrEn;
   logic         ZeroIn;
   logic         ParityIn;
   logic         OddIn;
   logic         SCWrEn;
   logic         SCIn;
   logic         ZeroFlag;
   logic         ParityFlag;
   logic         OddFlag;
   logic         SC_out;

   modport master (
      output RaddrA, RaddrB, WriteEn, Waddr, DataIn,
      output FlagWrEn, ZeroIn, ParityIn, OddIn, SCWrEn, SCIn,
      input  DataOutA, DataOutB, ZeroFlag, ParityFlag, OddFlag, SC_out
   );

   modport slave (
      input  RaddrA, RaddrB, WriteEn, Waddr, DataIn,
      input  FlagWrEn, ZeroIn, ParityIn, OddIn, SCWrEn, SCIn,
      output DataOutA, DataOutB, ZeroFlag, ParityFlag, OddFlag, SC_out
   );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with latched ALU flags and shift-carry bit; synchronous active-high reset.
// Define REG_BYPASS_EN to forward write data onto a read port that addresses the register being written.
module reg_file #(
   parameter int W = 8,
   parameter int A = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   reg_file_if.slave  bus
);
   localparam int DEPTH = 2 ** A;

   typedef struct packed {
      logic zero;
      logic parity;
      logic odd;
   } flags_t;

   logic [W-1:0] regs [DEPTH];
   flags_t       flags_q;
   logic         sc_q;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the array is cleared on reset because software expects all registers to read zero afterwards,
   // which rules out inferring a reset-less RAM macro here.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         regs <= '{default: '0};
      end else if (bus.WriteEn) begin
         regs[bus.Waddr] <= bus.DataIn;
      end
   end

   // Flag and shift-carry paths are independent of the register write path.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         flags_q <= '0;
         sc_q    <= 1'b0;
      end else begin
         if (bus.FlagWrEn) flags_q <= '{zero: bus.ZeroIn, parity: bus.ParityIn, odd: bus.OddIn};
         if (bus.SCWrEn)   sc_q    <= bus.SCIn;
      end
   end

   // NOTE: each read output is assigned from storage first so no path through this block can infer a latch.
   always_comb begin
      bus.DataOutA = regs[bus.RaddrA];
      bus.DataOutB = regs[bus.RaddrB];
`ifdef REG_BYPASS_EN
      if (bus.WriteEn && !Reset && (bus.Waddr == bus.RaddrA)) bus.DataOutA = bus.DataIn;
      if (bus.WriteEn && !Reset && (bus.Waddr == bus.RaddrB)) bus.DataOutB = bus.DataIn;
`else
      // Read-during-write returns the stored value; the new data appears after the edge.
`endif
   end

   assign bus.ZeroFlag   = flags_q.zero;
   assign bus.ParityFlag = flags_q.parity;
   assign bus.OddFlag    = flags_q.odd;
   assign bus.SC_out     = sc_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test-plan sequence with literal expectations, then random traffic
// compared every cycle against an array-based model of the architectural state.
module tb_reg_file;
   localparam int W = 8;
   localparam int A = 3;
   localparam int N = 2 ** A;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   reg_file_if #(.W(W), .A(A)) bus ();

   reg_file #(.W(W), .A(A)) dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: plain array plus flag/SC bits, updated on each rising edge.
   logic [W-1:0] m_regs [N];
   logic [2:0]   m_flags;
   logic         m_sc;
   bit           m_valid;

   initial m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) m_regs[i] = '0;
         m_flags = 3'b000;
         m_sc    = 1'b0;
         m_valid = 1'b1;
      end else begin
         if (bus.WriteEn)  m_regs[bus.Waddr] = bus.DataIn;
         if (bus.FlagWrEn) m_flags = {bus.ZeroIn, bus.ParityIn, bus.OddIn};
         if (bus.SCWrEn)   m_sc = bus.SCIn;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_read(input logic [A-1:0] raddr);
      logic [W-1:0] v;
      v = m_regs[raddr];
`ifdef REG_BYPASS_EN
      if (bus.WriteEn && !reset && bus.Waddr == raddr) v = bus.DataIn;
`endif
      return v;
   endfunction

   // Every-cycle comparison, sampled on the falling edge once the model has seen a reset.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc DataOutA", bus.DataOutA, exp_read(bus.RaddrA));
         check("cyc DataOutB", bus.DataOutB, exp_read(bus.RaddrB));
         check("cyc flags", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, m_flags);
         check("cyc SC_out", bus.SC_out, m_sc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.WriteEn  = 1'b0;
      bus.FlagWrEn = 1'b0;
      bus.SCWrEn   = 1'b0;
   endtask

   task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data);
      bus.WriteEn = 1'b1;
      bus.Waddr   = addr;
      bus.DataIn  = data;
      step();
      bus.WriteEn = 1'b0;
   endtask

   task automatic read_a(input logic [A-1:0] addr, input string name, input logic [W-1:0] exp);
      bus.RaddrA = addr;
      #1;
      check(name, bus.DataOutA, exp);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.RaddrA = '0; bus.RaddrB = '0; bus.Waddr = '0; bus.DataIn = '0;
      bus.ZeroIn = 1'b0; bus.ParityIn = 1'b0; bus.OddIn = 1'b0; bus.SCIn = 1'b0;
      idle();

      // Reset held two cycles with a write pending: the write must be discarded.
      reset = 1'b1;
      bus.WriteEn = 1'b1; bus.Waddr = 3'd2; bus.DataIn = 8'hFF;
      bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1; bus.SCWrEn = 1'b1; bus.SCIn = 1'b1;
      step();
      step();
      reset = 1'b0;
      idle();
      for (int r = 0; r < N; r++) read_a(3'(r), "reset reg", 8'h00);
      check("reset flags", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, 3'b000);
      check("reset SC_out", bus.SC_out, 1'b0);

      // Basic write/read on consecutive cycles.
      bus.WriteEn = 1'b1; bus.Waddr = 3'd3; bus.DataIn = 8'h2A;
      step();
      bus.Waddr = 3'd7; bus.DataIn = 8'h05;
      step();
      idle();
      bus.RaddrA = 3'd3; bus.RaddrB = 3'd7;
      #1;
      check("basic r3", bus.DataOutA, 8'h2A);
      check("basic r7", bus.DataOutB, 8'h05);
      check("model r3", m_regs[3], 8'h2A);
      read_a(3'd0, "basic r0 untouched", 8'h00);
      read_a(3'd6, "basic r6 untouched", 8'h00);

      // Read-during-write to r4.
      wr(3'd4, 8'h11);
      bus.RaddrA = 3'd4;
      bus.WriteEn = 1'b1; bus.Waddr = 3'd4; bus.DataIn = 8'h99;
      #1;
`ifdef REG_BYPASS_EN
      check("rdw same cycle", bus.DataOutA, 8'h99);
`else
      check("rdw same cycle", bus.DataOutA, 8'h11);
`endif
      step();
      idle();
      #1;
      check("rdw next cycle", bus.DataOutA, 8'h99);

      // Flags latch, then hold while FlagWrEn is low.
      bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1; bus.ParityIn = 1'b0; bus.OddIn = 1'b1;
      step();
      bus.FlagWrEn = 1'b0; bus.ZeroIn = 1'b0; bus.ParityIn = 1'b1; bus.OddIn = 1'b0;
      #1;
      check("flags latched", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, 3'b101);
      step();
      check("flags hold", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, 3'b101);

      // ALU loop: r1 + r2 written back to r5, then shift-carry latched.
      wr(3'd1, 8'h04);
      wr(3'd2, 8'h01);
      bus.RaddrA = 3'd1; bus.RaddrB = 3'd2;
      #1;
      check("alu opA", bus.DataOutA, 8'h04);
      check("alu opB", bus.DataOutB, 8'h01);
      wr(3'd5, 8'h05);
      read_a(3'd5, "alu r5", 8'h05);
      bus.SCWrEn = 1'b1; bus.SCIn = 1'b1;
      step();
      idle();
      #1;
      check("sc latched", bus.SC_out, 1'b1);

      // Reset mid-operation beats a concurrent write to r6 and flag update.
      wr(3'd6, 8'hC3);
      bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1; bus.ParityIn = 1'b1; bus.OddIn = 1'b1;
      step();
      idle();
      check("pre-reset flags", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, 3'b111);
      read_a(3'd6, "pre-reset r6", 8'hC3);
      reset = 1'b1;
      bus.WriteEn = 1'b1; bus.Waddr = 3'd6; bus.DataIn = 8'h3C;
      bus.FlagWrEn = 1'b1; bus.SCWrEn = 1'b1;
      step();
      reset = 1'b0;
      idle();
      read_a(3'd6, "mid reset r6", 8'h00);
      check("mid reset flags", {bus.ZeroFlag, bus.ParityFlag, bus.OddFlag}, 3'b000);
      check("mid reset SC_out", bus.SC_out, 1'b0);

      // Random traffic: every write path exercised independently, occasional reset.
      for (int c = 0; c < 3000; c++) begin
         reset        = ($urandom_range(0, 63) == 0);
         bus.RaddrA   = 3'($urandom_range(0, N - 1));
         bus.RaddrB   = ($urandom_range(0, 3) == 0) ? bus.RaddrA : 3'($urandom_range(0, N - 1));
         bus.WriteEn  = 1'($urandom_range(0, 1));
         bus.Waddr    = ($urandom_range(0, 2) == 0) ? bus.RaddrA : 3'($urandom_range(0, N - 1));
         bus.DataIn   = 8'($urandom);
         bus.FlagWrEn = ($urandom_range(0, 3) == 0);
         bus.ZeroIn   = 1'($urandom_range(0, 1));
         bus.ParityIn = 1'($urandom_range(0, 1));
         bus.OddIn    = 1'($urandom_range(0, 1));
         bus.SCWrEn   = ($urandom_range(0, 3) == 0);
         bus.SCIn     = 1'($urandom_range(0, 1));
         step();
      end
      reset = 1'b0;
      idle();
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
